// File: rtl/if_fetch_unit.sv
// if_fetch_unit: IF-stage fetch requester with a credit-limited prefetch buffer feeding ID
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc
);
    localparam int AW = $clog2(BUF_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH = (CW + 1)'(BUF_DEPTH);

    typedef enum logic {BOOT, RUN} state_t;

    state_t        state;
    logic [31:0]   fetch_pc;
    logic [31:0]   req_pc;
    logic          inflight;
    logic [CW-1:0] count;
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [31:0]   buf_pc    [BUF_DEPTH];
    logic [31:0]   buf_instr [BUF_DEPTH];
    logic          pop;
    logic          push;
    logic [CW:0]   occ;

    // request address, credit check and head presentation; a redirect sees an empty buffer
    always_comb begin
        imem_pc  = redirect_valid ? {redirect_pc[31:2], 2'b00} : fetch_pc;
        id_valid = count != '0;
        pop      = id_valid & id_ready;
        push     = inflight & ~redirect_valid;
        occ      = redirect_valid ? '0 : {1'b0, count} + (CW + 1)'(inflight) - (CW + 1)'(pop);
        imem_req = (state == RUN) && (occ < DEPTH);
        id_pc    = id_valid ? buf_pc[head] : '0;
        id_instr = id_valid ? buf_instr[head] : '0;
    end

    // control state: fetch pointer, in-flight tracking and buffer occupancy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= BOOT;
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            inflight <= 1'b0;
            count    <= '0;
            head     <= '0;
            tail     <= '0;
        end else begin
            state    <= RUN;
            inflight <= imem_req;
            req_pc   <= imem_pc;
            fetch_pc <= imem_req ? imem_pc + 32'd4 : imem_pc;
            if (redirect_valid) begin
                count <= '0;
                head  <= '0;
                tail  <= '0;
            end else begin
                count <= count + CW'(push) - CW'(pop);
                if (push) tail <= tail + 1'b1;
                if (pop) head <= head + 1'b1;
            end
        end
    end

    // buffer storage needs no reset: id outputs are masked while empty
    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc[tail]    <= req_pc;
            buf_instr[tail] <= imem_instr;
        end
    end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: scoreboard bench for the fetch unit, including a wrap-around instance
module tb_if_fetch_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_valid;
    logic        id_ready = 1'b1;
    logic [31:0] id_instr;
    logic [31:0] id_pc;

    logic        reset2 = 1'b0;
    logic        imem_req2;
    logic [31:0] imem_pc2;
    logic [31:0] imem_instr2 = '0;
    logic        id_valid2;
    logic [31:0] id_instr2;
    logic [31:0] id_pc2;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] q [$];
    logic [31:0] q2 [$];
    logic        found;

    always #5 clk = ~clk;

    if_fetch_unit dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_pc(imem_pc),
        .imem_instr(imem_instr), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc)
    );

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk(clk), .reset(reset2), .imem_req(imem_req2), .imem_pc(imem_pc2),
        .imem_instr(imem_instr2), .redirect_valid(1'b0), .redirect_pc(32'h0),
        .id_valid(id_valid2), .id_ready(1'b1), .id_instr(id_instr2), .id_pc(id_pc2)
    );

    // one-cycle memories returning addr>>2, junk when not requested
    always @(posedge clk) begin
        imem_instr  <= imem_req ? imem_pc >> 2 : 32'hBAD0_BAD0;
        imem_instr2 <= imem_req2 ? imem_pc2 >> 2 : 32'hBAD0_BAD0;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic sb_start(input logic [31:0] base);
        q.delete();
        for (int i = 0; i < 64; i++) q.push_back(base + 32'(4 * i));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // every accepted instruction must match the scoreboard head
    always @(negedge clk) begin
        if (reset && !redirect_valid && id_valid && id_ready) begin
            automatic logic [31:0] e = q.pop_front();
            chk("sb_pc", id_pc, e);
            chk("sb_instr", id_instr, e >> 2);
        end
        if (reset2 && id_valid2 && q2.size() != 0) begin
            automatic logic [31:0] e2 = q2.pop_front();
            chk("wrap_pc", id_pc2, e2);
            chk("wrap_instr", id_instr2, e2 >> 2);
        end
    end

    task automatic boot_seq();
        @(negedge clk);
        chk("c0_req", 32'(imem_req), 32'd0);
        chk("c0_valid", 32'(id_valid), 32'd0);
        step();
        @(negedge clk);
        chk("c1_req", 32'(imem_req), 32'd1);
        chk("c1_pc", imem_pc, 32'h0);
        step();
        @(negedge clk);
        chk("c2_valid", 32'(id_valid), 32'd0);
        step();
        @(negedge clk);
        chk("c3_valid", 32'(id_valid), 32'd1);
        chk("c3_pc", id_pc, 32'h0);
        chk("c3_instr", id_instr, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 4; i++) q2.push_back(32'hFFFF_FFF8 + 32'(4 * i));
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(id_valid), 32'd0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_pc", id_pc, 32'h0);
        reset = 1'b1;
        sb_start(32'h0);
        boot_seq();
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            id_ready = 1'b0;
            @(negedge clk);
            chk("stall_valid", 32'(id_valid), 32'd1);
            chk("stall_pc", id_pc, 32'h8);
            chk("stall_instr", id_instr, 32'h2);
            chk("stall_req", 32'(imem_req), 32'd0);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            id_ready = 1'b1;
            @(negedge clk);
            chk("release_valid", 32'(id_valid), 32'd1);
        end
        step();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (id_valid && id_pc == 32'h10) found = 1'b1;
            else step();
        end
        chk("wait_pc10", 32'(found), 32'd1);
        step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h1003;
        sb_start(32'h1000);
        @(negedge clk);
        chk("redir_pc", imem_pc, 32'h1000);
        chk("redir_req", 32'(imem_req), 32'd1);
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("redir_gap", 32'(id_valid), 32'd0);
        step();
        @(negedge clk);
        chk("redir_first_valid", 32'(id_valid), 32'd1);
        chk("redir_first_pc", id_pc, 32'h1000);
        repeat (4) step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        sb_start(32'h200);
        step();
        redirect_pc = 32'h300;
        sb_start(32'h300);
        @(negedge clk);
        chk("b2b_pc", imem_pc, 32'h300);
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("b2b_gap", 32'(id_valid), 32'd0);
        step();
        @(negedge clk);
        chk("b2b_first_pc", id_pc, 32'h300);
        repeat (5) step();
        id_ready = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        sb_start(32'h0);
        @(negedge clk);
        chk("mid_rst_valid", 32'(id_valid), 32'd0);
        chk("mid_rst_req", 32'(imem_req), 32'd0);
        chk("mid_rst_pc", id_pc, 32'h0);
        chk("mid_rst_instr", id_instr, 32'h0);
        step();
        reset = 1'b1;
        id_ready = 1'b1;
        boot_seq();
        repeat (6) step();
        reset2 = 1'b1;
        repeat (10) step();
        chk("wrap_left", 32'(q2.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
